// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit holding the architectural HI/LO registers.
//
// Arithmetic ops (MULT, MULTU, DIV, DIVU, MADD) latch their operands on the
// accepting edge, keep busy high for a fixed number of cycles, then write
// HI/LO on the edge where busy falls. MTHI/MTLO write HI/LO immediately.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT / MULTU / MADD
//   DIV_CYCLES   busy cycles for DIV / DIVU
//
// Ports:
//   clk    in   1   clock, all state changes on posedge
//   reset  in   1   synchronous active-high reset
//   start  in   1   request valid this cycle
//   op     in   4   1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=MADD, else no-op
//   A      in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
//   B      in   32  rt operand (divisor / multiplier)
//   busy   out  1   arithmetic op in progress
//   HI     out  32  architectural HI register
//   LO     out  32  architectural LO register
// ---------------------------------------------------------------------------
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   // Counter only has to hold N-1 for the longest op.
   localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // Power-up values match the reset values.
   logic [0:0]    state_q = S_IDLE;
   logic [CW-1:0] cnt_q   = '0;
   logic [3:0]    op_q    = '0;
   logic [31:0]   a_q     = '0;
   logic [31:0]   b_q     = '0;
   logic [31:0]   hi_q    = '0;
   logic [31:0]   lo_q    = '0;

   // ------------------------------------------------------------------
   // Result datapath, evaluated from the latched operands. Only its value
   // at the writeback edge matters; MADD therefore sees the HI/LO value
   // present at that edge.
   // ------------------------------------------------------------------
   logic [63:0] a_sx;
   logic [63:0] b_sx;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] madd_sum;

   logic        div_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   logic        wb_en;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;

   always_comb begin
      // Low 64 bits of the product of sign-extended operands equal the
      // signed 64-bit product, so one unsigned multiplier form covers both.
      a_sx     = {{32{a_q[31]}}, a_q};
      b_sx     = {{32{b_q[31]}}, b_q};
      prod_s   = a_sx * b_sx;
      prod_u   = {32'd0, a_q} * {32'd0, b_q};
      madd_sum = {hi_q, lo_q} + prod_s;
   end

   always_comb begin
      // Signed divide via magnitudes: 0x80000000 / -1 yields magnitude
      // 0x80000000, which negates back to itself, so it wraps without trap.
      div_signed = (op_q == OP_DIV);
      a_neg      = div_signed & a_q[31];
      b_neg      = div_signed & b_q[31];
      a_mag      = a_neg ? (32'd0 - a_q) : a_q;
      b_mag      = b_neg ? (32'd0 - b_q) : b_q;
      q_mag      = '0;
      r_mag      = '0;
      if (b_mag != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem  = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      wb_en = 1'b0;
      wb_hi = hi_q;
      wb_lo = lo_q;
      case (op_q)
         OP_MULT: begin
            wb_en = 1'b1;
            {wb_hi, wb_lo} = prod_s;
         end
         OP_MULTU: begin
            wb_en = 1'b1;
            {wb_hi, wb_lo} = prod_u;
         end
         OP_MADD: begin
            wb_en = 1'b1;
            {wb_hi, wb_lo} = madd_sum;
         end
         OP_DIV, OP_DIVU: begin
            // Divide by zero leaves HI/LO untouched.
            wb_en = (b_q != 32'd0);
            wb_hi = rem;
            wb_lo = quot;
         end
         default: begin
            wb_en = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Control: IDLE accepts requests, RUN counts down to the writeback.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_MADD: begin
                        op_q    <= op;
                        a_q     <= A;
                        b_q     <= B;
                        cnt_q   <= MULT_LOAD;
                        state_q <= S_RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        op_q    <= op;
                        a_q     <= A;
                        b_q     <= B;
                        cnt_q   <= DIV_LOAD;
                        state_q <= S_RUN;
                     end
                     OP_MTHI: hi_q <= A;
                     OP_MTLO: lo_q <= A;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (cnt_q == '0) begin
                  if (wb_en) begin
                     hi_q <= wb_hi;
                     lo_q <= wb_lo;
                  end
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = (state_q == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu.
// Directed cases plus randomized operations checked against a reference
// model built on plain 64-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int total = 0;
   int bad   = 0;

   // Model of the architectural registers.
   logic [63:0] acc = '0;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_hi"}, HI, acc[63:32]);
      check({tag, "_lo"}, LO, acc[31:0]);
   endtask

   // Reference semantics: result of an arithmetic op given the accumulator.
   function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
      longint sa;
      longint sb;
      longint unsigned ua;
      longint unsigned ub;
      longint q;
      longint r;
      longint unsigned uq;
      longint unsigned ur;
      logic [63:0] res;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      res = cur;
      case (o)
         4'd1: res = sa * sb;
         4'd2: res = ua * ub;
         4'd7: res = cur + 64'(sa * sb);
         4'd3: if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
         end
         4'd4: if (b != 0) begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
         end
         default: res = cur;
      endcase
      return res;
   endfunction

   // Issue an arithmetic op and follow it through its busy window.
   // junk: 0 = quiet inputs while busy, 1 = random requests, 2 = MTHI requests.
   task automatic do_arith(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int junk, input string tag);
      int n;
      logic [63:0] exp;
      n = (o == 4'd3 || o == 4'd4) ? DC : MC;
      start = 1'b1; op = o; A = a; B = b;
      tick();
      for (int k = 0; k < n; k++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check_regs({tag, "_hold"});
         start = (junk != 0);
         op    = (junk == 2) ? 4'd5 : 4'($urandom_range(0, 15));
         A     = $urandom;
         B     = $urandom;
         tick();
      end
      start = 1'b0;
      exp = ref_result(o, a, b, acc);
      acc = exp;
      check({tag, "_done"}, 32'(busy), 32'd0);
      check_regs(tag);
   endtask

   task automatic do_move(input logic [3:0] o, input logic [31:0] a, input string tag);
      start = 1'b1; op = o; A = a;
      tick();
      start = 1'b0;
      if (o == 4'd5) acc[63:32] = a;
      else if (o == 4'd6) acc[31:0] = a;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check_regs(tag);
   endtask

   initial begin
      logic [3:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  noops [3];
      noops[0] = 4'd0; noops[1] = 4'd8; noops[2] = 4'd15;

      // Power-up state, before any reset.
      #1;
      check("pwr_busy", 32'(busy), 32'd0);
      check_regs("pwr");

      // Reset with a simultaneous MTHI: ignored.
      reset = 1'b1; start = 1'b1; op = 4'd5; A = 32'h1234_5678;
      tick();
      reset = 1'b0; start = 1'b0;
      acc = '0;
      check("rst_busy", 32'(busy), 32'd0);
      check_regs("rst");

      // Directed arithmetic.
      do_arith(4'd1, 32'hFFFF_FFFE, 32'd3, 0, "mult");
      check("mult_hi_k", HI, 32'hFFFF_FFFF);
      check("mult_lo_k", LO, 32'hFFFF_FFFA);
      do_arith(4'd2, 32'hFFFF_FFFE, 32'd3, 0, "multu");
      check("multu_hi_k", HI, 32'h0000_0002);
      check("multu_lo_k", LO, 32'hFFFF_FFFA);
      do_arith(4'd3, 32'hFFFF_FFF9, 32'd2, 0, "div");
      check("div_hi_k", HI, 32'hFFFF_FFFF);
      check("div_lo_k", LO, 32'hFFFF_FFFD);
      do_arith(4'd4, 32'd7, 32'd0, 0, "divu0");
      do_arith(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divovf");
      check("divovf_hi_k", HI, 32'h0000_0000);
      check("divovf_lo_k", LO, 32'h8000_0000);

      // MTHI / MTLO / MADD.
      do_move(4'd5, 32'd5, "mthi");
      do_move(4'd6, 32'd1, "mtlo");
      do_arith(4'd7, 32'd2, 32'd3, 0, "madd1");
      check("madd1_hi_k", HI, 32'd5);
      check("madd1_lo_k", LO, 32'd7);
      do_arith(4'd7, 32'hFFFF_FFFF, 32'd1, 0, "madd2");
      check("madd2_hi_k", HI, 32'd5);
      check("madd2_lo_k", LO, 32'd6);

      // No-op codes change nothing.
      foreach (noops[i]) do_move(noops[i], $urandom, "noop");

      // MTHI requested while busy is ignored.
      do_arith(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 2, "mult_mthi");

      // Back-to-back on the first edge with busy low.
      do_arith(4'd1, 32'd100, 32'hFFFF_FF00, 1, "b2b_a");
      do_arith(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, "b2b_b");

      // Reset during a divide discards the pending result.
      start = 1'b1; op = 4'd3; A = 32'd1000; B = 32'd7;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      acc = '0;
      check("rstrun_busy", 32'(busy), 32'd0);
      check_regs("rstrun");
      for (int k = 0; k < DC; k++) begin
         tick();
         check_regs("rstrun_late");
      end
      check("rstrun_idle", 32'(busy), 32'd0);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(1, 9));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            default: ;
         endcase
         if (ro == 4'd5 || ro == 4'd6 || ro > 4'd7) do_move(ro, ra, "rnd_mv");
         else do_arith(ro, ra, rb, int'($urandom_range(0, 1)), "rnd_ar");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
